data_sram_like_bridge: RTL
==========================

Name: data_sram_like_bridge

Overview:
- Sits between the CPU top's data-SRAM port (en/wen/addr/wdata/rdata, single-cycle style) and an sram-like request/ack bus (req/addr_ok/data_ok).
- Converts each CPU data access into one bus transaction and stalls the pipeline until that transaction completes.
- Derives transfer size and byte address from the write strobe. Buffers read data so the CPU sees it in a single completion cycle.

Parameters:
- ADDR_WIDTH, 32, width of cpu_addr and data_addr.
- HOLD_RDATA, 1, 1: cpu_rdata holds the last completed read until the next read completes; 0: cpu_rdata is 0 outside the DONE cycle.

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- cpu_en  input  1  CPU data access valid; held stable by the CPU while cpu_stall=1.
- cpu_wen  input  4  byte write strobe; 0 means read.
- cpu_addr  input  ADDR_WIDTH  word-aligned physical address.
- cpu_wdata  input  32  write data, byte lanes already positioned.
- cpu_rdata  output  32  read data, valid in the DONE cycle.
- cpu_stall  output  1  pipeline stall request.
- data_req  output  1  bus request.
- data_wr  output  1  1 = write.
- data_size  output  2  0 = byte, 1 = half, 2 = word.
- data_addr  output  ADDR_WIDTH  byte address.
- data_wdata  output  32  write data.
- data_addr_ok  input  1  request accepted.
- data_data_ok  input  1  write done / read data valid.
- data_rdata  input  32  read data.

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset: IDLE, all outputs 0, request/rdata registers 0.
- IDLE:
  - cpu_en=1 → latch wr/size/addr/wdata, go to REQ.
  - cpu_stall = cpu_en (combinational).
- REQ:
  - data_req=1, driven from latched registers only.
  - data_addr_ok=1 → go to WAIT; otherwise stay. Request fields are stable while in REQ.
- WAIT:
  - data_req=0.
  - data_data_ok=1 → capture data_rdata (reads only), go to DONE.
  - data_data_ok is sampled only in WAIT; the bus guarantees data_ok arrives at least 1 cycle after addr_ok.
- DONE:
  - cpu_stall=0; cpu_rdata = captured data; unconditional return to IDLE.
  - The pipeline advances on the edge ending DONE. A new request is seen in IDLE on the next cycle, with no back-to-back reissue.
- cpu_stall = 1 in REQ and WAIT regardless of cpu_en.
- Minimum latency: request cycle in IDLE, addr_ok in REQ, data_ok in WAIT, data in DONE → 3 stall cycles.
- Size/address mapping from cpu_wen:
  - 0000 → read, size 2, offset 0.
  - 1111 → size 2, offset 0.
  - 0011 → size 1, offset 0.
  - 1100 → size 1, offset 2.
  - 0001 / 0010 / 0100 / 1000 → size 0, offsets 0 / 1 / 2 / 3.
  - Any other pattern → size 2, offset 0, full-word write (CPU must not issue these; documented fallback).
- data_addr = {cpu_addr[ADDR_WIDTH-1:2], offset}.
- cpu_en deasserted in REQ or WAIT (flush): the outstanding transaction still completes and data is discarded. DONE is entered, with stall=0.
- Asynchronous reset mid-transaction returns to IDLE immediately, data_req=0. Bus-side recovery is the bus's responsibility.
- Only one transaction is outstanding at a time.

Optional Feature:
- Macro DATA_BRIDGE_PERF_CNT_EN.
- Defined:
  - Extra output port stall_cycles [31:0] counts every cycle with cpu_stall=1.
  - Extra output port access_cnt [31:0] increments on each DONE.
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Read, zero-wait bus: cpu_en=1, wen=0, addr=0x1000; addr_ok in REQ, data_ok next cycle with rdata=0xDEADBEEF → req for 1 cycle, size=2, data_addr=0x1000, stall for 3 cycles, cpu_rdata=0xDEADBEEF in DONE.
- Byte write: wen=0100, addr=0x2000, wdata=0x00AB0000 → wr=1, size=0, data_addr=0x2002, data_wdata=0x00AB0000.
- Backpressure: addr_ok withheld 4 cycles, data_ok 3 cycles later → req held with fields stable for 5 cycles, stall=1 for 9 cycles total, single DONE.
- Back-to-back: two reads at 0x10 and 0x14 issued consecutively → exactly two bus requests, no duplicate; each result appears in its own DONE cycle.
- Flush: cpu_en drops in WAIT → transaction completes on data_ok, DONE, then IDLE with no new request; with HOLD_RDATA=1, cpu_rdata shows the captured word.
- Reset mid-REQ: resetn=0 while data_req=1 → data_req and cpu_stall go to 0 asynchronously, state IDLE; with DATA_BRIDGE_PERF_CNT_EN, stall_cycles=0.

Source files
------------

// File: rtl/data_sram_like_bridge_if.sv
// ============================================================================
// data_sram_like_bridge_if : CPU data-SRAM port and sram-like bus bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface data_sram_like_bridge_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  cpu_en;
   logic [3:0]            cpu_wen;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [31:0]           cpu_wdata;
   logic [31:0]           cpu_rdata;
   logic                  cpu_stall;

   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [ADDR_WIDTH-1:0] data_addr;
   logic [31:0]           data_wdata;
   logic                  data_addr_ok;
   logic                  data_data_ok;
   logic [31:0]           data_rdata;

   // Bridge view: serves the CPU, masters the sram-like bus.
   modport master (
      input  cpu_en, cpu_wen, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   // Environment view: CPU pipeline plus bus responder.
   modport slave (
      output cpu_en, cpu_wen, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

`default_nettype wire

// File: rtl/data_sram_like_bridge.sv
// ============================================================================
// data_sram_like_bridge : CPU data-SRAM port to sram-like req/ack bus bridge
// Optional perf counters enabled by DATA_BRIDGE_PERF_CNT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module data_sram_like_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter bit HOLD_RDATA = 1'b1
) (
   input  wire logic clk,
   input  wire logic resetn,
   data_sram_like_bridge_if.master bif
`ifdef DATA_BRIDGE_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] access_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  wr_q, wr_d;
   logic [1:0]            size_q, size_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            map_size;
   logic [1:0]            map_off;
   logic                  req_c;
   logic                  stall_c;

   always_comb begin
      map_size = 2'd2;
      map_off  = 2'd0;
      case (bif.cpu_wen)
         4'b0011: begin map_size = 2'd1; map_off = 2'd0; end
         4'b1100: begin map_size = 2'd1; map_off = 2'd2; end
         4'b0001: begin map_size = 2'd0; map_off = 2'd0; end
         4'b0010: begin map_size = 2'd0; map_off = 2'd1; end
         4'b0100: begin map_size = 2'd0; map_off = 2'd2; end
         4'b1000: begin map_size = 2'd0; map_off = 2'd3; end
         default: begin map_size = 2'd2; map_off = 2'd0; end
      endcase
   end

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      req_c   = 1'b0;
      stall_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall_c = bif.cpu_en;
            if (bif.cpu_en) begin
               wr_d    = (bif.cpu_wen != 4'b0000);
               size_d  = map_size;
               addr_d  = {bif.cpu_addr[ADDR_WIDTH-1:2], map_off};
               wdata_d = bif.cpu_wdata;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            req_c   = 1'b1;
            stall_c = 1'b1;
            if (bif.data_addr_ok) state_d = S_WAIT;
         end
         S_WAIT: begin
            stall_c = 1'b1;
            if (bif.data_data_ok) begin
               if (!wr_q) rdata_d = bif.data_rdata;
               state_d = S_DONE;
            end
         end
         // DONE never reissues: the CPU's held request is consumed here.
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Stall is gated by reset so it drops asynchronously even while cpu_en is held.
   assign bif.cpu_stall  = stall_c & resetn;
   assign bif.data_req   = req_c;
   assign bif.data_wr    = wr_q;
   assign bif.data_size  = size_q;
   assign bif.data_addr  = addr_q;
   assign bif.data_wdata = wdata_q;

   generate
      if (HOLD_RDATA) begin : g_rdata_hold
         assign bif.cpu_rdata = rdata_q;
      end else begin : g_rdata_pulse
         assign bif.cpu_rdata = (state_q == S_DONE) ? rdata_q : 32'd0;
      end
   endgenerate

`ifdef DATA_BRIDGE_PERF_CNT_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] access_cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cycles_q <= 32'd0;
         access_cnt_q   <= 32'd0;
      end else begin
         if (stall_c)            stall_cycles_q <= stall_cycles_q + 32'd1;
         if (state_q == S_DONE)  access_cnt_q   <= access_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign access_cnt   = access_cnt_q;
`endif

endmodule

`default_nettype wire
